// File: rtl/nebula_bus_pkg.sv
// Shared types and constants for the nebula core-bus bridge.
package nebula_bus_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;
    localparam logic [WB_DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/wb_core_bridge.sv
// Wishbone classic slave that turns nebula-window hits into single core-bus req/done handshakes.
// Optional bus timeout with sticky error flag: define WB_BRIDGE_TIMEOUT_EN.
module wb_core_bridge
    import nebula_bus_pkg::*;
#(
    parameter logic [31:0]          BASE_ADDR = 32'h3000_0000,
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          TIMEOUT   = 255,
    parameter logic [WB_DATA_W-1:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [WB_SEL_W-1:0]  wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [WB_DATA_W-1:0] wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [WB_DATA_W-1:0] wbs_dat_o,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [WB_SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0]    bus_adr_o,
    output logic [WB_DATA_W-1:0] bus_wdat_o,
    input  logic [WB_DATA_W-1:0] bus_rdat_i,
    input  logic                 bus_done_i,
    output logic                 err_o
);

    bridge_state_t        state_q;
    logic                 ack_q;
    logic [WB_DATA_W-1:0] dat_q;
    logic                 req_q;
    logic                 we_q;
    logic [WB_SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0]    adr_q;
    logic [WB_DATA_W-1:0] wdat_q;
    logic                 abort_q;
    logic                 active_c;
    logic                 hit_c;

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;
`endif

    assign active_c = wbs_cyc_i & wbs_stb_i;
    assign hit_c    = active_c && (wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);

    // Bridge FSM; the core cannot abort, so a dropped WB cycle only suppresses the ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            abort_q <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    // ack_q high here means stb still belongs to the access just acked
                    if (hit_c && !ack_q) begin
                        we_q   <= wbs_we_i;
                        sel_q  <= wbs_sel_i;
                        adr_q  <= wbs_adr_i[ADDR_W-1:0];
                        wdat_q <= wbs_dat_i;
                        if (wbs_sel_i != '0) begin
                            state_q <= REQ;
                        end else begin
                            dat_q   <= '0;
                            state_q <= ACK;
                        end
                    end
                end
                REQ: begin
                    req_q   <= 1'b1;
                    state_q <= WAIT;
                    if (!active_c) abort_q <= 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    if (!active_c) abort_q <= 1'b1;
                    if (bus_done_i) begin
                        req_q   <= 1'b0;
                        dat_q   <= we_q ? '0 : bus_rdat_i;
                        state_q <= ACK;
                    end
`ifdef WB_BRIDGE_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        dat_q   <= we_q ? '0 : ERR_DATA;
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                ACK: begin
                    ack_q   <= active_c & ~abort_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign bus_req_o  = req_q;
    assign bus_we_o   = we_q;
    assign bus_sel_o  = sel_q;
    assign bus_adr_o  = adr_q;
    assign bus_wdat_o = wdat_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
    assign err_o = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT), ERR_DATA};
    assign err_o      = 1'b0;
`endif

endmodule
